// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle Yu Core control FSM (optional JAL path: YUCORE_JAL_EN)
`timescale 1ns/1ps
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] immSrc,
  output logic       regWrite,
  output logic       instrDone,
  output logic       illegalInstr
);

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
`ifdef YUCORE_JAL_EN
  localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ,
`ifdef YUCORE_JAL_EN
    S_JAL,
`endif
    S_ILLEGAL
  } state_t;

  // Moore bits of the next state are registered; *_rdy / pc_zero mark enables
  // that are finished combinationally with memReady or zero.
  typedef struct packed {
    logic       adr;
    logic [1:0] res, srca, srcb, aluop;
    logic       regw, done, done_rdy, pc_rdy, pc_zero, pc_one, ir_rdy, memw, ill;
  } ctrl_t;

  state_t state;
  ctrl_t  ctrl;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.res = 2'b10; c.srcb = 2'b10; c.pc_rdy = 1'b1; c.ir_rdy = 1'b1; end
      S_DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
      S_MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
      S_MEMREAD:  c.adr = 1'b1;
      S_MEMWB:    begin c.res = 2'b01; c.regw = 1'b1; c.done = 1'b1; end
      S_MEMWRITE: begin c.adr = 1'b1; c.memw = 1'b1; c.done_rdy = 1'b1; end
      S_EXECUTER: begin c.srca = 2'b10; c.aluop = 2'b10; end
      S_EXECUTEI: begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = 2'b10; end
      S_ALUWB:    begin c.regw = 1'b1; c.done = 1'b1; end
      S_BEQ:      begin c.srca = 2'b10; c.aluop = 2'b01; c.pc_zero = 1'b1; c.done = 1'b1; end
`ifdef YUCORE_JAL_EN
      S_JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pc_one = 1'b1; end
`endif
      S_ILLEGAL:  c.ill = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t next_of(input state_t s, input logic [6:0] op, input logic rdy);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = S_EXECUTER;
          OP_I:         n = S_EXECUTEI;
          OP_B:         n = S_BEQ;
`ifdef YUCORE_JAL_EN
          OP_JAL:       n = S_JAL;
`endif
          default:      n = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   n = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  n = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: n = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTER, S_EXECUTEI: n = S_ALUWB;
`ifdef YUCORE_JAL_EN
      S_JAL:      n = S_ALUWB;
`endif
      S_ILLEGAL:  n = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ctrl  <= decode(S_FETCH);
    end else begin
      state <= next_of(state, opcode, memReady);
      ctrl  <= decode(next_of(state, opcode, memReady));
    end
  end

  always_comb begin
    immSrc = 2'b00;
    case (opcode)
      OP_SW:   immSrc = 2'b01;
      OP_B:    immSrc = 2'b10;
`ifdef YUCORE_JAL_EN
      OP_JAL:  immSrc = 2'b11;
`endif
      default: immSrc = 2'b00;
    endcase
  end

  // Enables are forced low while reset is asserted so no partial write escapes.
  assign pcWrite      = ~reset & ((ctrl.pc_rdy & memReady) | (ctrl.pc_zero & zero) | ctrl.pc_one);
  assign irWrite      = ~reset & ctrl.ir_rdy & memReady;
  assign memWrite     = ~reset & ctrl.memw;
  assign regWrite     = ~reset & ctrl.regw;
  assign instrDone    = ~reset & (ctrl.done | (ctrl.done_rdy & memReady));
  assign illegalInstr = ~reset & ctrl.ill;
  assign adrSrc       = ctrl.adr;
  assign resultSrc    = ctrl.res;
  assign ALUSrcA      = ctrl.srca;
  assign ALUSrcB      = ctrl.srcb;
  assign ALUOp        = ctrl.aluop;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller (halting and non-halting builds)
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_ER = 6, P_EI = 7, P_AWB = 8, P_BEQ = 9, P_JAL = 10, P_ILL = 11;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BT = 7'b1100011, JT = 7'b1101111, BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1, reset0 = 1'b1;
  logic       zero = 1'b0, memReady = 1'b0;
  logic [6:0] opcode = 7'd0;

  logic       pcw, adr, mw, irw, rw, dn, ill;
  logic [1:0] res, sa, sb, aop, imm;
  logic       pcw0, adr0, mw0, irw0, rw0, dn0, ill0;
  logic [1:0] res0, sa0, sb0, aop0, imm0;

  int    tests = 0;
  int    fails = 0;
  string cur_tag = "";

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcWrite(pcw), .adrSrc(adr), .memWrite(mw), .irWrite(irw), .resultSrc(res),
    .ALUSrcA(sa), .ALUSrcB(sb), .ALUOp(aop), .immSrc(imm), .regWrite(rw),
    .instrDone(dn), .illegalInstr(ill)
  );

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcWrite(pcw0), .adrSrc(adr0), .memWrite(mw0), .irWrite(irw0), .resultSrc(res0),
    .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0), .immSrc(imm0), .regWrite(rw0),
    .instrDone(dn0), .illegalInstr(ill0)
  );

  wire [16:0] obs  = {pcw, adr, mw, irw, res, sa, sb, aop, imm, rw, dn, ill};
  wire [16:0] obs0 = {pcw0, adr0, mw0, irw0, res0, sa0, sb0, aop0, imm0, rw0, dn0, ill0};

  // Expected outputs for one cycle, straight from the per-step control table.
  function automatic logic [16:0] exp_vec(input int ph, input logic [6:0] op,
                                          input logic mr, input logic z, input logic rst);
    logic pc = 1'b0, a_sel = 1'b0, mwr = 1'b0, ir = 1'b0, rwr = 1'b0, done = 1'b0, il = 1'b0;
    logic [1:0] rs = 2'd0, a = 2'd0, b = 2'd0, alu = 2'd0, im = 2'd0;
    case (ph)
      P_F:   begin rs = 2'd2; b = 2'd2; pc = mr; ir = mr; end
      P_D:   begin a = 2'd1; b = 2'd1; end
      P_MA:  begin a = 2'd2; b = 2'd1; end
      P_MR:  a_sel = 1'b1;
      P_MWB: begin rs = 2'd1; rwr = 1'b1; done = 1'b1; end
      P_MW:  begin a_sel = 1'b1; mwr = 1'b1; done = mr; end
      P_ER:  begin a = 2'd2; alu = 2'd2; end
      P_EI:  begin a = 2'd2; b = 2'd1; alu = 2'd2; end
      P_AWB: begin rwr = 1'b1; done = 1'b1; end
      P_BEQ: begin a = 2'd2; alu = 2'd1; pc = z; done = 1'b1; end
      P_JAL: begin a = 2'd1; b = 2'd2; pc = 1'b1; end
      P_ILL: il = 1'b1;
      default: ;
    endcase
    if (rst) {pc, mwr, ir, rwr, done, il} = 6'd0;
    case (op)
      SW: im = 2'd1;
      BT: im = 2'd2;
`ifdef YUCORE_JAL_EN
      JT: im = 2'd3;
`endif
      default: im = 2'd0;
    endcase
    return {pc, a_sel, mwr, ir, rs, a, b, alu, im, rwr, done, il};
  endfunction

  task automatic check(input string tag, input logic [16:0] o, input logic [16:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
    end
  endtask

  // One clock: drive inputs, compare both instances mid-cycle, advance. ph0 < 0 skips dut0.
  task automatic step(input int ph, input int ph0, input logic [6:0] op, input logic mr, input logic z);
    opcode = op; memReady = mr; zero = z;
    @(negedge clk);
    check($sformatf("%s dut ph%0d", cur_tag, ph), obs, exp_vec(ph, op, mr, z, reset));
    if (ph0 >= 0)
      check($sformatf("%s dut0 ph%0d", cur_tag, ph0), obs0, exp_vec(ph0, op, mr, z, reset0));
    @(posedge clk); #1;
  endtask

  // After ILLEGAL: halting copy stays put, the other fetches; both are then reset.
  task automatic recover(input int hold);
    step(P_ILL, P_F, 7'($urandom), 1'b0, 1'($urandom));
    reset0 = 1'b1;
    repeat (hold) step(P_ILL, P_F, 7'($urandom), 1'($urandom), 1'($urandom));
    reset = 1'b1;
    step(P_ILL, P_F, 7'($urandom), 1'($urandom), 1'($urandom));
    step(P_F, P_F, 7'($urandom), 1'($urandom), 1'($urandom));
    reset = 1'b0; reset0 = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input logic zv, input int hold);
    int q[$];
    int n;
    logic [6:0] o;
    case (op)
      LW: q = {P_F, P_D, P_MA, P_MR, P_MWB};
      SW: q = {P_F, P_D, P_MA, P_MW};
      RT: q = {P_F, P_D, P_ER, P_AWB};
      IT: q = {P_F, P_D, P_EI, P_AWB};
      BT: q = {P_F, P_D, P_BEQ};
`ifdef YUCORE_JAL_EN
      JT: q = {P_F, P_D, P_JAL, P_AWB};
`endif
      default: q = {P_F, P_D, P_ILL};
    endcase
    foreach (q[k]) begin
      o = (q[k] == P_D || q[k] == P_MA) ? op : 7'($urandom);
      if (q[k] == P_F || q[k] == P_MR || q[k] == P_MW) begin
        n = (q[k] == P_F) ? fs : ms;
        repeat (n) step(q[k], q[k], o, 1'b0, 1'($urandom));
        step(q[k], q[k], o, 1'b1, 1'($urandom));
      end else begin
        step(q[k], q[k], o, 1'($urandom), (q[k] == P_BEQ) ? zv : 1'($urandom));
      end
    end
    if (q[q.size()-1] == P_ILL) recover(hold);
  endtask

  initial begin
    logic [6:0] ops [8];
    logic [6:0] pick;
    ops = '{LW, SW, RT, IT, BT, JT, BAD, 7'd0};

    cur_tag = "reset";
    @(posedge clk); #1;
    step(P_F, P_F, LW, 1'b1, 1'b0);
    step(P_F, P_F, LW, 1'b1, 1'b0);
    reset = 1'b0; reset0 = 1'b0;

    cur_tag = "lw";        run_instr(LW, 0, 0, 1'b0, 0);
    cur_tag = "sw_stall";  run_instr(SW, 0, 3, 1'b0, 0);
    cur_tag = "beq_z1";    run_instr(BT, 0, 0, 1'b1, 0);
    cur_tag = "beq_z0";    run_instr(BT, 0, 0, 1'b0, 0);
    cur_tag = "r_type";    run_instr(RT, 0, 0, 1'b0, 0);
    cur_tag = "i_type";    run_instr(IT, 0, 0, 1'b0, 0);
    cur_tag = "fetch_stall"; run_instr(LW, 2, 2, 1'b0, 0);
    cur_tag = "illegal";   run_instr(BAD, 0, 0, 1'b0, 11);

    cur_tag = "reset_mid_sw";
    step(P_F, P_F, 7'($urandom), 1'b1, 1'b0);
    step(P_D, P_D, SW, 1'b0, 1'b0);
    step(P_MA, P_MA, SW, 1'b1, 1'b0);
    reset = 1'b1; reset0 = 1'b1;
    step(P_MW, P_MW, SW, 1'b1, 1'b0);
    step(P_F, P_F, SW, 1'b1, 1'b1);
    reset = 1'b0; reset0 = 1'b0;
    cur_tag = "after_reset"; run_instr(RT, 0, 0, 1'b0, 0);

    cur_tag = "jal";       run_instr(JT, 1, 0, 1'b0, 3);

    for (int i = 0; i < 40; i++) begin
      pick = ops[$urandom_range(0, 7)];
      if (pick == 7'd0) pick = 7'($urandom);
      cur_tag = $sformatf("rand%0d_op%02h", i, pick);
      run_instr(pick, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
